query_patch_aggregator: RTL and testbench

Upstream neighbour of the query row buffer. Accepts query patch elements one at a time from the chip I/O over a valid/ready handshake. Packs ELEMS_PER_WORD elements into one DATA_WIDTH word and presents it to the buffer's write side as a one-cycle sender_enable pulse with sender_data. Counts completed words and flags done when a full query row (NUM_WORDS) has been delivered.

---
 rtl/query_patch_aggregator_pkg.sv | 7 +
 rtl/query_patch_aggregator_if.sv | 15 +
 rtl/query_patch_aggregator_packer.sv | 36 +++
 rtl/query_patch_aggregator.sv | 66 ++++++
 tb/tb_query_patch_aggregator.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/query_patch_aggregator_pkg.sv
// query_patch_aggregator_pkg: shared state encoding and word-geometry defaults for aggregator and buffer
package query_patch_aggregator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_ELEM_WIDTH = 11;
  localparam int DEF_ELEMS_PER_WORD = 5;
  localparam int DEF_DATA_WIDTH = DEF_ELEM_WIDTH * DEF_ELEMS_PER_WORD;
endpackage

// File: rtl/query_patch_aggregator_if.sv
// query_patch_aggregator_if: element handshake from chip I/O and word strobe toward the query buffer
interface query_patch_aggregator_if
  import query_patch_aggregator_pkg::*;
#(
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  io_valid;
  logic [ELEM_WIDTH-1:0] io_data;
  logic                  io_ready;
  logic                  sender_enable;
  logic [DATA_WIDTH-1:0] sender_data;
  modport slave  (input io_valid, io_data, output io_ready, sender_enable, sender_data);
  modport master (output io_valid, io_data, input io_ready, sender_enable, sender_data);
endinterface

// File: rtl/query_patch_aggregator_packer.sv
// query_elem_packer: element counter plus insert register; word_o is the word including the element on elem_i
module query_elem_packer
  import query_patch_aggregator_pkg::*;
#(
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int ELEMS_PER_WORD = DEF_ELEMS_PER_WORD,
  localparam int DATA_WIDTH = ELEM_WIDTH * ELEMS_PER_WORD,
  localparam int CW = ELEMS_PER_WORD > 1 ? $clog2(ELEMS_PER_WORD) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  xfer_i,
  input  logic [ELEM_WIDTH-1:0] elem_i,
  output logic                  word_complete_o,
  output logic [DATA_WIDTH-1:0] word_o
);
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  always_comb begin
    word_o = sr_q;
    word_o[cnt_q*ELEM_WIDTH +: ELEM_WIDTH] = elem_i;
    word_complete_o = xfer_i && cnt_q == CW'(ELEMS_PER_WORD - 1);
    cnt_d = (clear_i || word_complete_o) ? '0 : xfer_i ? cnt_q + 1'b1 : cnt_q;
    sr_d = (xfer_i && !clear_i) ? word_o : sr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/query_patch_aggregator.sv
// query_patch_aggregator: packs I/O elements into buffer words, counts words and flags a full query row
module query_patch_aggregator
  import query_patch_aggregator_pkg::*;
#(
  parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
  parameter int ELEMS_PER_WORD = DEF_ELEMS_PER_WORD,
  parameter int NUM_WORDS = 128,
  localparam int DATA_WIDTH = ELEM_WIDTH * ELEMS_PER_WORD,
  localparam int CW = $clog2(NUM_WORDS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fsm_enable_i,
  input  logic                     restart_i,
  query_patch_aggregator_if.slave  bus,
  output logic [CW-1:0]            word_count_o,
  output logic                     done_o
);
  state_e                state_q, state_d;
  logic                  sender_enable_q, sender_enable_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] sender_data_q, sender_data_d, word;
  logic [CW-1:0]         word_count_q, word_count_d;
  logic                  xfer, word_complete, emit, last_word;
  assign bus.io_ready      = state_q == COLLECT && fsm_enable_i;
  assign bus.sender_enable = sender_enable_q;
  assign bus.sender_data   = sender_data_q;
  assign word_count_o      = word_count_q;
  assign done_o            = done_q;
  assign xfer              = bus.io_valid && bus.io_ready;
  query_elem_packer #(.ELEM_WIDTH(ELEM_WIDTH), .ELEMS_PER_WORD(ELEMS_PER_WORD)) u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (restart_i),
    .xfer_i         (xfer),
    .elem_i         (bus.io_data),
    .word_complete_o(word_complete),
    .word_o         (word)
  );
  // restart overrides everything except sender_data, which keeps its last word
  always_comb begin
    emit = word_complete && !restart_i;
    last_word = word_count_q == CW'(NUM_WORDS - 1);
    state_d = restart_i ? IDLE
            : (state_q == IDLE && fsm_enable_i) ? COLLECT
            : (emit && last_word) ? DONE : state_q;
    sender_enable_d = emit;
    sender_data_d = emit ? word : sender_data_q;
    word_count_d = restart_i ? '0 : word_count_q + CW'(emit);
    done_d = !restart_i && (done_q || (emit && last_word));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sender_enable_q <= 1'b0;
      sender_data_q   <= '0;
      word_count_q    <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      sender_enable_q <= sender_enable_d;
      sender_data_q   <= sender_data_d;
      word_count_q    <= word_count_d;
      done_q          <= done_d;
    end
  end
endmodule

// File: tb/tb_query_patch_aggregator.sv
// tb_query_patch_aggregator: randomized scenarios checked against a queue-based row-packing model
module tb_query_patch_aggregator;
  localparam int EW = 11;
  localparam int EPW = 5;
  localparam int DW = EW * EPW;
  localparam int NW = 128;
  logic clk, rst_n, fsm_en, restart, done;
  logic [7:0] wc;
  int total, bad;
  query_patch_aggregator_if #(.ELEM_WIDTH(EW), .DATA_WIDTH(DW)) io ();
  query_patch_aggregator #(.ELEM_WIDTH(EW), .ELEMS_PER_WORD(EPW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .fsm_enable_i(fsm_en), .restart_i(restart),
    .bus(io), .word_count_o(wc), .done_o(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // model: accepted elements queue up; every EPW of them form one word, LSB-first
  logic [EW-1:0] m_q[$];
  int m_phase, m_count;
  bit m_pulse, m_done;
  logic [DW-1:0] m_data;
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete(); m_phase = 0; m_count = 0; m_pulse = 0; m_done = 0; m_data = '0;
      end else if (restart) begin
        m_q.delete(); m_phase = 0; m_count = 0; m_pulse = 0; m_done = 0;
      end else begin
        m_pulse = 0;
        if (m_phase == 1 && fsm_en && io.io_valid) begin
          m_q.push_back(io.io_data);
          if (m_q.size() == EPW) begin
            m_data = '0;
            foreach (m_q[k]) m_data = m_data | (DW'(m_q[k]) << (k * EW));
            m_q.delete();
            m_pulse = 1;
            m_count++;
            if (m_count == NW) begin m_done = 1; m_phase = 2; end
          end
        end else if (m_phase == 0 && fsm_en) m_phase = 1;
      end
    end
  end
  task automatic clear_all();
    @(negedge clk); restart = 1; io.io_valid = 0; fsm_en = 0;
    @(negedge clk); restart = 0; fsm_en = 1;
  endtask
  task automatic test_reset();
    rst_n = 0; fsm_en = 1; restart = 0; io.io_valid = 1; io.io_data = '1;
    @(negedge clk);
    total++;
    if ({io.io_ready, io.sender_enable, io.sender_data, wc, done} !== '0) begin
      bad++; $display("FAIL reset: rdy=%b se=%b data=%h wc=%0d done=%b want all 0", io.io_ready, io.sender_enable, io.sender_data, wc, done);
    end
    io.io_valid = 0;
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_basic();
    logic [DW-1:0] exp_w = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    clear_all();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL basic c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      if (c == 5) begin
        total++;
        if ({io.sender_enable, io.sender_data, wc} !== {1'b1, exp_w, 8'd1}) begin
          bad++; $display("FAIL basic word: se=%b data=%h wc=%0d want 1 %h 1", io.sender_enable, io.sender_data, wc, exp_w);
        end
      end
      io.io_valid = c < 5; io.io_data = EW'(c + 1);
    end
  endtask
  task automatic test_stream();
    int pulses = 0, last = -1;
    clear_all();
    for (int c = 0; c < 660; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL stream c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      if (io.sender_enable) begin
        pulses++;
        total++;
        if (io.sender_data !== m_data) begin bad++; $display("FAIL stream data: got %h want %h", io.sender_data, m_data); end
        if (last >= 0) begin
          total++;
          if (c - last != EPW) begin bad++; $display("FAIL stream gap: got %0d want %0d", c - last, EPW); end
        end
        last = c;
      end
      io.io_valid = 1; io.io_data = EW'(c % 2048);
    end
    total++;
    if (pulses != NW || done !== 1'b1 || io.io_ready !== 1'b0) begin
      bad++; $display("FAIL stream end: pulses=%0d done=%b rdy=%b want %0d 1 0", pulses, done, io.io_ready, NW);
    end
  endtask
  task automatic test_toggle();
    int last = -1;
    clear_all();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL toggle c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      if (io.sender_enable) begin
        total++;
        if (io.sender_data !== m_data || (last >= 0 && c - last != 2 * EPW)) begin
          bad++; $display("FAIL toggle word: data=%h gap=%0d want %h gap %0d", io.sender_data, c - last, m_data, 2 * EPW);
        end
        last = c;
      end
      io.io_valid = (c % 2) == 0; io.io_data = EW'($urandom);
    end
  endtask
  task automatic test_fsm_gap();
    int pulses = 0;
    clear_all();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL gap c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      if (io.sender_enable) begin
        pulses++;
        total++;
        if (io.sender_data !== m_data) begin bad++; $display("FAIL gap data: got %h want %h", io.sender_data, m_data); end
      end
      fsm_en = !(c >= 3 && c < 10); io.io_valid = c < 12; io.io_data = EW'($urandom);
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL gap pulses: got %0d want 1", pulses); end
  endtask
  task automatic test_restart();
    clear_all();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL restart c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      if (io.sender_enable) begin
        total++;
        if (io.sender_data !== m_data) begin bad++; $display("FAIL restart data: got %h want %h", io.sender_data, m_data); end
      end
      if (c == 48) begin
        total++;
        if ({wc, done, io.io_ready, io.sender_enable} !== 11'd0) begin
          bad++; $display("FAIL restart clear: wc=%0d done=%b rdy=%b se=%b want 0", wc, done, io.io_ready, io.sender_enable);
        end
      end
      restart = c == 47; io.io_valid = 1; io.io_data = EW'($urandom);
    end
  endtask
  task automatic test_async_reset();
    clear_all();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL arst c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      if (io.sender_enable) begin
        total++;
        if (io.sender_data !== m_data) begin bad++; $display("FAIL arst data: got %h want %h", io.sender_data, m_data); end
      end
      if (c == 14) begin
        @(posedge clk); #2 rst_n = 0; #1;
        total++;
        if ({io.io_ready, io.sender_enable, io.sender_data, wc, done} !== '0) begin
          bad++; $display("FAIL arst immediate: rdy=%b se=%b data=%h wc=%0d done=%b want all 0", io.io_ready, io.sender_enable, io.sender_data, wc, done);
        end
        @(negedge clk); rst_n = 1;
      end
      io.io_valid = 1; io.io_data = EW'($urandom);
    end
  endtask
  task automatic test_random();
    clear_all();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      total++;
      if ({io.io_ready, io.sender_enable, done, wc} !== {m_phase == 1 && fsm_en, m_pulse, m_done, 8'(m_count)}) begin
        bad++; $display("FAIL random c=%0d: rdy/se/done/wc=%b/%b/%b/%0d want %b/%b/%b/%0d", c, io.io_ready, io.sender_enable, done, wc, m_phase == 1 && fsm_en, m_pulse, m_done, m_count);
      end
      total++;
      if (io.sender_data !== m_data) begin bad++; $display("FAIL random data c=%0d: got %h want %h", c, io.sender_data, m_data); end
      io.io_valid = $urandom_range(0, 3) != 0; fsm_en = $urandom_range(0, 7) != 0;
      restart = $urandom_range(0, 60) == 0; io.io_data = EW'($urandom);
    end
    restart = 0;
  endtask
  initial begin
    total = 0; bad = 0;
    test_reset();
    test_basic();
    test_stream();
    test_toggle();
    test_fsm_gap();
    test_restart();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
